// File: rtl/bus_control_pkg.sv
// Shared definitions for the multi-channel bus controller.
// Contents: FSM state encoding, turnaround-counter width helper and the
// synchroniser stage count.
package bus_control_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ST_W        = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_TURN  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Width of a down-counter that must hold n-1; never narrower than 1 bit.
    function automatic int unsigned ta_cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// Synchroniser plus falling-edge detector for one active-low strobe.
// Ports: clk, rst_n (async, active low), strobe_n (async pin),
//        strobe_s (synchronised strobe), fall_c (1-cycle falling-edge flag).
// All flops reset to 1 so a strobe reads as inactive out of reset.
module strobe_sync
    import bus_control_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic strobe_s,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe_s = sync_q[SYNC_STAGES-1];
    assign fall_c   = prev_q & ~strobe_s;

endmodule

// File: rtl/bus_control_mc.sv
// Multi-channel clocked bus controller: synchronises WR_n/RD_n, decodes addr
// to one of NCH channels, gates accesses with IWR/IRD, holds the register
// file and drives registered read data with a bus-turnaround gap.
// Ports: clk, rst_n, WR_n, RD_n, addr, data_in, IWR, IRD  (inputs)
//        RegEn, BusEn, data_out, reg_q, conflict          (outputs)
// Optional: BUSCTL_PARITY_EN adds par_inject (in) and par_err (out) with one
// stored even-parity bit per register.
module bus_control_mc
    import bus_control_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned NCH       = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned TA_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef BUSCTL_PARITY_EN
    input  logic              par_inject,
    output logic              par_err,
`endif
    input  logic              WR_n,
    input  logic              RD_n,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     data_in,
    input  logic [NCH-1:0]    IWR,
    input  logic [NCH-1:0]    IRD,
    output logic [NCH-1:0]    RegEn,
    output logic              BusEn,
    output logic [DW-1:0]     data_out,
    output logic [NCH*DW-1:0] reg_q,
    output logic              conflict
);

    localparam int unsigned    CW      = ta_cnt_w(TA_CYCLES);
    localparam logic [CW-1:0]  TA_LOAD = CW'(TA_CYCLES - 1);

    logic          wr_s, rd_s, wr_fall_c, rd_fall_c;
    state_t        state;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic [CW-1:0] ta_cnt;

    logic [AW-1:0]  mux_addr_c;
    logic [NCH-1:0] sel_c;
    logic           wr_ok_c, rd_ok_c;
    logic [DW-1:0]  rd_word_c;
`ifdef BUSCTL_PARITY_EN
    logic [NCH-1:0] par_q;
    logic           lat_inj;
    logic           rd_par_c;
`endif

    strobe_sync u_wr_sync (.clk(clk), .rst_n(rst_n), .strobe_n(WR_n), .strobe_s(wr_s), .fall_c(wr_fall_c));
    strobe_sync u_rd_sync (.clk(clk), .rst_n(rst_n), .strobe_n(RD_n), .strobe_s(rd_s), .fall_c(rd_fall_c));

    // Channel decode: live addr while idle (edge cycle), latched addr afterwards.
    // Out-of-range addresses select nothing, so they are never permitted.
    always_comb begin
        mux_addr_c = (state == ST_IDLE) ? addr : lat_addr;
        sel_c      = '0;
        wr_ok_c    = 1'b0;
        rd_ok_c    = 1'b0;
        rd_word_c  = '0;
`ifdef BUSCTL_PARITY_EN
        rd_par_c   = 1'b0;
`endif
        for (int k = 0; k < NCH; k++) begin
            if (mux_addr_c == AW'(k)) begin
                sel_c[k]  = 1'b1;
                wr_ok_c   = IWR[k];
                rd_ok_c   = IRD[k];
                rd_word_c = reg_q[k*DW +: DW];
`ifdef BUSCTL_PARITY_EN
                rd_par_c  = par_q[k];
`endif
            end
        end
    end

    // Control FSM, register file and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lat_addr <= '0;
            lat_data <= '0;
            ta_cnt   <= '0;
            RegEn    <= '0;
            BusEn    <= 1'b0;
            data_out <= '0;
            reg_q    <= '0;
            conflict <= 1'b0;
`ifdef BUSCTL_PARITY_EN
            par_q    <= '0;
            lat_inj  <= 1'b0;
            par_err  <= 1'b0;
`endif
        end else begin
            RegEn <= '0;

            // RegEn is only ever high for the first WRITE cycle, so it doubles
            // as the register-file write enable.
            for (int k = 0; k < NCH; k++) begin
                if (RegEn[k]) begin
                    reg_q[k*DW +: DW] <= lat_data;
`ifdef BUSCTL_PARITY_EN
                    par_q[k]          <= (^lat_data) ^ lat_inj;
`endif
                end
            end

            if (!wr_s && !rd_s) begin
                state    <= ST_ERR;
                conflict <= 1'b1;
                BusEn    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_fall_c) begin
                            state    <= ST_WRITE;
                            lat_addr <= addr;
                            lat_data <= data_in;
                            RegEn    <= wr_ok_c ? sel_c : '0;
`ifdef BUSCTL_PARITY_EN
                            lat_inj  <= par_inject;
`endif
                        end else if (rd_fall_c) begin
                            state    <= ST_READ;
                            lat_addr <= addr;
                            BusEn    <= rd_ok_c;
                            if (rd_ok_c) begin
                                data_out <= rd_word_c;
                            end
`ifdef BUSCTL_PARITY_EN
                            par_err  <= rd_ok_c & (rd_par_c ^ (^rd_word_c));
`endif
                        end
                    end
                    ST_WRITE: begin
                        if (wr_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_READ: begin
                        if (rd_s) begin
                            state  <= ST_TURN;
                            BusEn  <= 1'b0;
                            ta_cnt <= TA_LOAD;
                        end else begin
                            BusEn <= rd_ok_c;
                            if (rd_ok_c) begin
                                data_out <= rd_word_c;
`ifdef BUSCTL_PARITY_EN
                                par_err  <= rd_par_c ^ (^rd_word_c);
`endif
                            end
                        end
                    end
                    ST_TURN: begin
                        // Strobe edges seen here are deliberately dropped.
                        if (ta_cnt == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            ta_cnt <= ta_cnt - CW'(1);
                        end
                    end
                    ST_ERR: begin
                        if (wr_s && rd_s) begin
                            state    <= ST_IDLE;
                            conflict <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/bus_control_mc.md
Name: bus_control_mc

Overview:
Multi-channel, clocked successor to the single-channel combinational bus enable logic. The block does the following:
- Synchronises the external active-low strobes WR_n/RD_n.
- Decodes an address to one of NCH channels.
- Gates each access with per-channel internal enables IWR/IRD.
- Holds an internal register file.
- Drives a registered read-data bus with a tri-state enable and an enforced bus turnaround.
It sits between the external parallel bus pins and the internal register/IO logic.

Parameters:
- DW, 8, data width.
- NCH, 4, number of channels/registers (2..16).
- AW, 2, address width; NCH <= 2**AW.
- TA_CYCLES, 2, idle cycles after a read before BusEn may reassert (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous and active-low; one clock.
- WR_n  in  1  external write strobe, active low, asynchronous to clk.
- RD_n  in  1  external read strobe, active low, asynchronous to clk.
- addr  in  AW  channel address; sampled when the strobe edge is detected.
- data_in  in  DW  write data; sampled with addr.
- IWR  in  NCH  per-channel internal write permit.
- IRD  in  NCH  per-channel internal read permit.
- RegEn  out  NCH  one-hot, single-cycle write-strobe pulse for the addressed channel.
- BusEn  out  1  tri-state buffer enable for data_out.
- data_out  out  DW  registered read data.
- reg_q  out  NCH*DW  flattened register file contents; channel k at [k*DW +: DW].
- conflict  out  1  high while an illegal simultaneous RD/WR is active.

Behaviour:
- Reset (async, rst_n=0):
  - RegEn=0, BusEn=0, data_out=0, conflict=0, all registers=0.
  - Synchroniser flops reset to 1 (strobes inactive).
  - FSM goes to IDLE.
- Synchroniser: two-flop sync per strobe; wr_s and rd_s are the second-stage outputs. A third flop holds the previous value for edge detection.
- FSM states: IDLE, WRITE, READ, TURN, ERR.
- IDLE:
  - wr_s=0 and rd_s=0 -> ERR.
  - Falling edge of wr_s -> WRITE; addr and data_in are latched on this cycle.
  - Falling edge of rd_s -> READ; addr is latched.
- WRITE (exactly 1 cycle):
  - If addr<NCH and IWR[addr]=1: RegEn[addr]=1, and reg[addr]<=data_in at the end of the cycle.
  - Otherwise no RegEn and no register change (silent ignore).
  - Next state: wait in WRITE-hold (sub-flag) until wr_s=1, then IDLE. RegEn pulses once per strobe.
- Write latency: WR_n pin falling edge -> RegEn high on the 3rd rising clk edge. reg_q updates on the following edge.
- READ:
  - If addr<NCH and IRD[addr]=1: BusEn=1, and data_out<=reg[addr] each cycle.
  - Otherwise BusEn stays 0 and data_out holds its value.
  - Exit when rd_s=1 -> TURN.
- Read latency: RD_n pin fall -> BusEn high on the 3rd edge, with valid data_out on the same edge.
- TURN:
  - BusEn=0; counter loads TA_CYCLES-1 and decrements; goes to IDLE when it reaches 0.
  - Strobe edges during TURN are ignored. A strobe still low on return to IDLE is not a new edge and is not serviced.
- ERR:
  - Entered whenever wr_s=0 and rd_s=0 in any state.
  - conflict=1, BusEn=0, RegEn=0.
  - Leaves to IDLE only when wr_s=1 and rd_s=1.
- IWR/IRD are sampled every cycle. Deasserting IRD[addr] mid-read drops BusEn on the next edge.
- reg_q reflects register contents continuously (registered).
- Reset mid-operation: immediate return to reset values, with BusEn=0 asynchronously. A write in flight is lost.

Optional Feature:
Macro BUSCTL_PARITY_EN.
- Defined:
  - Adds one stored even-parity bit per register, computed from data_in on write.
  - Adds output port par_err (1 bit). par_err is registered and set with data_out when the stored parity mismatches recomputed parity of reg[addr] during READ; it clears on the next read-start or on reset.
  - Adds input port par_inject (1 bit), used in test to invert the stored parity bit on write.
- Undefined: no parity storage and no extra ports. Behaviour is otherwise identical.

Decomposition:
- Package bus_control_pkg holds:
  - the FSM state encoding (localparam ST_IDLE..ST_ERR, 3 bits);
  - the TA counter width function (clog2);
  - the sync stage count constant SYNC_STAGES=2.
- One sub-module, strobe_sync, is natural: a 2-flop synchroniser plus falling-edge detector, reset to 1, instanced twice.

Test Plan:
- Write, then read back:
  - Stimulus: IWR=4'b1111, addr=2, data_in=8'hA5, WR_n low 6 cycles.
  - Required: RegEn=4'b0100 for exactly 1 cycle, 3 edges after the fall; reg_q[23:16]=8'hA5.
  - Then with IRD=4'b0100 and RD_n low: BusEn=1 and data_out=8'hA5.
- Permit masking: IWR=4'b1011, write 8'h3C to addr 2 -> RegEn stays 0 and reg_q unchanged. With IRD[1]=0, a read of addr 1 keeps BusEn=0.
- Turnaround: TA_CYCLES=3. RD_n rises, then falls again 1 cycle after rd_s deasserts -> BusEn low for at least 3 cycles, and the second read is not serviced.
- Conflict: WR_n and RD_n low together -> conflict=1 within 3 cycles, no RegEn, BusEn=0. conflict clears only after both strobes are high.
- Async reset mid-read: rst_n=0 while BusEn=1 -> BusEn=0 and data_out=0 without a clock edge, and all reg_q=0.
- With BUSCTL_PARITY_EN: write 8'h01 with par_inject=1, then read -> par_err=1 alongside data_out=8'h01. Write without inject, then read -> par_err=0.
